// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and helpers for the operand fetch stage.
//   registerFileAdressBits / registerDataWidth : register file geometry
//   opcodeWidth / immWidth                      : instruction fields carried to EX
//   stallCountWidth                             : width of the load-use stall counter
//   addrHit()                                   : "this write port targets register a"
package operand_fetch_stage_pkg;

    localparam int registerFileAdressBits = 5;
    localparam int registerDataWidth      = 16;
    localparam int opcodeWidth            = 4;
    localparam int immWidth               = 16;
    localparam int stallCountWidth        = 16;

    // True when an enabled write targets the given read address.
    function automatic logic addrHit(
        input logic                              writeEn,
        input logic [registerFileAdressBits-1:0] writeAddr,
        input logic [registerFileAdressBits-1:0] readAddr
    );
        return writeEn && (writeAddr == readAddr);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_forward_mux.sv
// Combinational operand resolution for one source register.
// Ports:
//   src                    source register address
//   regData                register file read data for src
//   exRegWrite/exMemRead   EX write enable / EX is a load (result not ready)
//   exRd/exResult          EX destination and ALU result
//   wbRegWrite/wbRd/wbData WB write port (same as the register file write port)
//   operand                resolved value
// Priority: r0 -> EX (younger) -> WB (not yet in the file) -> register file.
module forward_mux
    import operand_fetch_stage_pkg::*;
(
    input  logic [registerFileAdressBits-1:0] src,
    input  logic [registerDataWidth-1:0]      regData,
    input  logic                              exRegWrite,
    input  logic                              exMemRead,
    input  logic [registerFileAdressBits-1:0] exRd,
    input  logic [registerDataWidth-1:0]      exResult,
    input  logic                              wbRegWrite,
    input  logic [registerFileAdressBits-1:0] wbRd,
    input  logic [registerDataWidth-1:0]      wbData,
    output logic [registerDataWidth-1:0]      operand
);

    always_comb begin
        operand = regData;
        if (src == '0) begin
            operand = '0;
        end else if (addrHit(exRegWrite && !exMemRead, exRd, src)) begin
            // A load in EX has no data yet; the hazard logic stalls instead.
            operand = exResult;
        end else if (addrHit(wbRegWrite, wbRd, src)) begin
            operand = wbData;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: drives register file read addresses, forwards
// from EX/WB, stalls on load-use hazards and holds the ID/EX register.
// Ports:
//   clk, clear                 clock, asynchronous active-high reset
//   in_*                       decode side instruction + valid/ready
//   flush                      squash ID/EX register (branch taken)
//   readReg1/2, dataReg1/2     register file read ports
//   ex_*, wb_*                 forwarding sources
//   out_*                      ID/EX register + valid/ready to EX
//   stall_count                saturating count of load-use stall cycles
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int opWidth    = opcodeWidth,
    parameter int iWidth     = immWidth,
    parameter int stallWidth = stallCountWidth
) (
    input  logic                              clk,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [registerFileAdressBits-1:0] in_rs1,
    input  logic [registerFileAdressBits-1:0] in_rs2,
    input  logic [registerFileAdressBits-1:0] in_rd,
    input  logic [opWidth-1:0]                in_op,
    input  logic [iWidth-1:0]                 in_imm,
    input  logic                              in_regWrite,
    input  logic                              in_memRead,
    input  logic                              flush,
    output logic [registerFileAdressBits-1:0] readReg1,
    output logic [registerFileAdressBits-1:0] readReg2,
    input  logic [registerDataWidth-1:0]      dataReg1,
    input  logic [registerDataWidth-1:0]      dataReg2,
    input  logic                              ex_regWrite,
    input  logic                              ex_memRead,
    input  logic [registerFileAdressBits-1:0] ex_rd,
    input  logic [registerDataWidth-1:0]      ex_result,
    input  logic                              wb_regWrite,
    input  logic [registerFileAdressBits-1:0] wb_rd,
    input  logic [registerDataWidth-1:0]      wb_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [opWidth-1:0]                out_op,
    output logic [iWidth-1:0]                 out_imm,
    output logic [registerFileAdressBits-1:0] out_rd,
    output logic                              out_regWrite,
    output logic                              out_memRead,
    output logic [registerDataWidth-1:0]      out_opA,
    output logic [registerDataWidth-1:0]      out_opB,
    output logic [stallWidth-1:0]             stall_count
);

    logic [registerFileAdressBits-1:0] srcAddr  [2];
    logic [registerDataWidth-1:0]      srcData  [2];
    logic [registerDataWidth-1:0]      resolved [2];

    assign readReg1   = in_rs1;
    assign readReg2   = in_rs2;
    assign srcAddr[0] = in_rs1;
    assign srcAddr[1] = in_rs2;
    assign srcData[0] = dataReg1;
    assign srcData[1] = dataReg2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            forward_mux u_forward_mux (
                .src        (srcAddr[gi]),
                .regData    (srcData[gi]),
                .exRegWrite (ex_regWrite),
                .exMemRead  (ex_memRead),
                .exRd       (ex_rd),
                .exResult   (ex_result),
                .wbRegWrite (wb_regWrite),
                .wbRd       (wb_rd),
                .wbData     (wb_data),
                .operand    (resolved[gi])
            );
        end
    endgenerate

    logic validReg;
    logic slotFree;
    logic loadUse;
    logic stallEvent;
    logic accept;

    // Slot can take a new instruction when empty or being drained this cycle.
    assign slotFree   = !validReg || out_ready;
    assign loadUse    = in_valid && ex_regWrite && ex_memRead && (ex_rd != '0)
                        && ((ex_rd == in_rs1) || (ex_rd == in_rs2));
    assign stallEvent = loadUse && slotFree;
    // flush also drops whatever decode presents in the same cycle.
    assign in_ready   = !clear && !flush && !loadUse && slotFree;
    assign accept     = in_valid && in_ready;
    assign out_valid  = validReg;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            validReg     <= 1'b0;
            out_op       <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_regWrite <= 1'b0;
            out_memRead  <= 1'b0;
            out_opA      <= '0;
            out_opB      <= '0;
        end else begin
            if (flush) begin
                validReg <= 1'b0;
            end else if (accept) begin
                validReg     <= 1'b1;
                out_op       <= in_op;
                out_imm      <= in_imm;
                out_rd       <= in_rd;
                out_regWrite <= in_regWrite;
                out_memRead  <= in_memRead;
                out_opA      <= resolved[0];
                out_opB      <= resolved[1];
            end else if (slotFree) begin
                // Drained with nothing to replace it, or a load-use bubble.
                validReg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            stall_count <= '0;
        end else if (stallEvent && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_op;
    logic [15:0] in_imm;
    logic        in_regWrite, in_memRead;
    logic        flush;
    logic [4:0]  readReg1, readReg2;
    logic [15:0] dataReg1, dataReg2;
    logic        ex_regWrite, ex_memRead;
    logic [4:0]  ex_rd;
    logic [15:0] ex_result;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [15:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_regWrite, out_memRead;
    logic [15:0] out_opA, out_opB;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_op(in_op), .in_imm(in_imm),
        .in_regWrite(in_regWrite), .in_memRead(in_memRead),
        .flush(flush),
        .readReg1(readReg1), .readReg2(readReg2),
        .dataReg1(dataReg1), .dataReg2(dataReg2),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_imm(out_imm), .out_rd(out_rd),
        .out_regWrite(out_regWrite), .out_memRead(out_memRead),
        .out_opA(out_opA), .out_opB(out_opB),
        .stall_count(stall_count)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one comparison per transfer into EX.
    always @(negedge clk) begin
        if (!clear && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer%0d: unexpected output A=%h B=%h, expected no transfer",
                         xfers, out_opA, out_opB);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_op !== e.op || out_imm !== e.imm || out_rd !== e.rd ||
                    out_regWrite !== e.rw || out_memRead !== e.mr ||
                    out_opA !== e.a || out_opB !== e.b) begin
                    errors++;
                    $display("FAIL xfer%0d: got op=%h imm=%h rd=%0d rw=%b mr=%b A=%h B=%h expected op=%h imm=%h rd=%0d rw=%b mr=%b A=%h B=%h",
                             xfers, out_op, out_imm, out_rd, out_regWrite, out_memRead, out_opA, out_opB,
                             e.op, e.imm, e.rd, e.rw, e.mr, e.a, e.b);
                end else begin
                    $display("xfer%0d ok op=%h rd=%0d A=%h B=%h", xfers, out_op, out_rd, out_opA, out_opB);
                end
            end
            xfers++;
        end
    end

    // Present an instruction, wait (bounded) for acceptance, optionally push expectation.
    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [3:0] op, input logic [15:0] imm, input logic rw,
                        input logic mr, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] expA, input logic [15:0] expB, input bit push);
        bit accepted = 0;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_op = op; in_imm = imm;
        in_regWrite = rw; in_memRead = mr; dataReg1 = d1; dataReg2 = d2;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (i == 0) chk("readReg1", {27'b0, readReg1}, {27'b0, rs1});
            if (in_ready) accepted = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected acceptance");
        end else if (push) begin
            exp_t e;
            e.op = op; e.imm = imm; e.rd = rd; e.rw = rw; e.mr = mr; e.a = expA; e.b = expB;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clear = 1'b1; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_op = 0;
        in_imm = 0; in_regWrite = 0; in_memRead = 0; flush = 0; dataReg1 = 0; dataReg2 = 0;
        ex_regWrite = 0; ex_memRead = 0; ex_rd = 0; ex_result = 0;
        wb_regWrite = 0; wb_rd = 0; wb_data = 0; out_ready = 1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_stall_count", {16'b0, stall_count}, 32'd0);
        chk("rst_out_opA", {16'b0, out_opA}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;

        // No hazard, 1-cycle latency
        send(5'd3, 5'd4, 5'd7, 4'h1, 16'h0010, 1, 0, 16'h1234, 16'h4321, 16'h1234, 16'h4321, 1);
        chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_out_opA", {16'b0, out_opA}, 32'h1234);
        idle(1);

        // EX beats WB on the same register
        ex_regWrite = 1; ex_rd = 5; ex_result = 16'hAAAA;
        wb_regWrite = 1; wb_rd = 5; wb_data = 16'hBBBB;
        send(5'd5, 5'd6, 5'd8, 4'h2, 16'h0020, 1, 0, 16'h1111, 16'h6666, 16'hAAAA, 16'h6666, 1);
        // WB alone
        ex_regWrite = 0;
        send(5'd5, 5'd6, 5'd9, 4'h3, 16'h0030, 0, 1, 16'h1111, 16'h6666, 16'hBBBB, 16'h6666, 1);
        idle(1);

        // Register zero ignores forwarding
        ex_regWrite = 1; ex_memRead = 0; ex_rd = 0; ex_result = 16'hFFFF;
        wb_regWrite = 1; wb_rd = 0; wb_data = 16'hEEEE;
        send(5'd1, 5'd0, 5'd10, 4'h4, 16'h0040, 1, 0, 16'h0101, 16'h7777, 16'h0101, 16'h0000, 1);
        idle(1);
        wb_regWrite = 0;

        // Load-use: stall once, then forward the EX result
        ex_regWrite = 1; ex_memRead = 1; ex_rd = 2; ex_result = 16'h0BAD;
        in_rs1 = 1; in_rs2 = 2; in_rd = 11; in_op = 4'h5; in_imm = 16'h0050;
        in_regWrite = 1; in_memRead = 0; dataReg1 = 16'h0111; dataReg2 = 16'h2222;
        in_valid = 1;
        @(negedge clk);
        chk("lu_in_ready", {31'b0, in_ready}, 32'd0);
        chk("lu_readReg2", {27'b0, readReg2}, 32'd2);
        @(posedge clk); #1;
        ex_memRead = 0; ex_result = 16'hCAFE;
        @(negedge clk);
        chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        chk("lu_stall_count", {16'b0, stall_count}, 32'd1);
        chk("lu_in_ready_after", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        begin
            exp_t e;
            e.op = 4'h5; e.imm = 16'h0050; e.rd = 11; e.rw = 1; e.mr = 0;
            e.a = 16'h0111; e.b = 16'hCAFE;
            sb.push_back(e);
        end
        in_valid = 0;
        ex_regWrite = 0;
        idle(1);

        // Backpressure then flush of the held instruction
        out_ready = 0;
        send(5'd12, 5'd13, 5'd14, 4'h6, 16'h0060, 1, 0, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5, 0);
        in_rs1 = 12; in_rs2 = 13; dataReg1 = 16'h9999; dataReg2 = 16'h8888; in_valid = 1;
        ex_regWrite = 1; ex_rd = 12; ex_result = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_out_opA", {16'b0, out_opA}, 32'h5A5A);
            chk("bp_out_opB", {16'b0, out_opB}, 32'hA5A5);
            @(posedge clk); #1;
        end
        ex_regWrite = 0;
        flush = 1;
        @(negedge clk);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1;

        // Flush on an empty slot drops the presented instruction
        in_valid = 1; flush = 1;
        @(negedge clk);
        chk("fl_empty_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("fl_empty_out_valid", {31'b0, out_valid}, 32'd0);
        chk("stall_count_hold", {16'b0, stall_count}, 32'd1);
        @(posedge clk); #1;

        // Recovery after flush
        send(5'd15, 5'd16, 5'd17, 4'h7, 16'h0070, 0, 0, 16'h3333, 16'h4444, 16'h3333, 16'h4444, 1);
        idle(2);

        // Asynchronous clear while holding a valid instruction
        out_ready = 0;
        send(5'd18, 5'd19, 5'd20, 4'h8, 16'h0080, 1, 0, 16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF, 0);
        chk("mid_out_valid", {31'b0, out_valid}, 32'd1);
        clear = 1;
        #1;
        chk("clr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_out_opA", {16'b0, out_opA}, 32'd0);
        chk("clr_stall_count", {16'b0, stall_count}, 32'd0);
        chk("clr_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 0; out_ready = 1;
        idle(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
